// File: rtl/load_store_unit.sv
// Load/store unit: sequences one aligned 32-bit data-memory access
// over a req/gnt/rvalid bus and extends load results to 32 bits.
// Ports: pipeline side start_i, mem_read_i, mem_write_i, read_size_i,
// read_signed_i, addr_i, store_data_i -> busy_o, done_o, err_o,
// load_data_o; bus side mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
// mem_wdata_o <- mem_gnt_i, mem_rvalid_i, mem_rdata_i.
// Optional: define LSU_TIMEOUT_EN to enable a gnt/rvalid watchdog
// that faults after TIMEOUT_CYCLES cycles in REQ or WAIT_RD.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        mem_read_i,
    input  logic [3:0]  mem_write_i,
    input  logic [1:0]  read_size_i,
    input  logic        read_signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_RD, DONE, FAULT
    } state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] load_q;

    logic [1:0]  req_size;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  mask;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] lane;
    logic [31:0] ext;
    logic        wd_expired;

    // Access size comes from the write mask for stores, else read_size_i.
    always_comb begin
        req_size = read_size_i;
        illegal  = 1'b0;
        unique case (mem_write_i)
            4'b0000: ;
            4'b0001: req_size = 2'd0;
            4'b0011: req_size = 2'd1;
            4'b1111: req_size = 2'd2;
            default: illegal = 1'b1;
        endcase
        if (mem_read_i && mem_write_i != 4'b0000)
            illegal = 1'b1;
        if (!mem_read_i && mem_write_i == 4'b0000)
            illegal = 1'b1;
        if (mem_read_i && read_size_i == 2'd3)
            illegal = 1'b1;
        misaligned = (req_size == 2'd1 && addr_i[0]) ||
                     (req_size == 2'd2 && addr_i[1:0] != 2'b00);
    end

    always_comb begin
        mask  = 4'b1111;
        wdata = store_data_i;
        unique case (req_size)
            2'd0: begin
                mask  = 4'b0001;
                wdata = {4{store_data_i[7:0]}};
            end
            2'd1: begin
                mask  = 4'b0011;
                wdata = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
        be = mask << addr_i[1:0];
    end

    // Legal halves sit at offset 0 or 2, so one byte shift covers both.
    always_comb begin
        lane = mem_rdata_i >> {off_q, 3'b000};
        ext  = lane;
        unique case (size_q)
            2'd0: ext = {{24{sgn_q & lane[7]}}, lane[7:0]};
            2'd1: ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
            default: ;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] wd_q;
    logic          wd_run;
    logic          wd_enter;

    assign wd_run   = (state == REQ) || (state == WAIT_RD);
    assign wd_enter = (state_nxt == REQ && state != REQ) ||
                      (state_nxt == WAIT_RD && state != WAIT_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_q <= '0;
        else if (wd_enter)
            wd_q <= '0;
        else if (wd_run)
            wd_q <= wd_q + 1'b1;
    end

    // Counter holds k-1 during the k-th waiting cycle.
    assign wd_expired = wd_run && (wd_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (start_i)
                    state_nxt = (illegal || misaligned) ? FAULT : REQ;
            REQ:
                if (mem_gnt_i)
                    state_nxt = we_q ? DONE : WAIT_RD;
                else if (wd_expired)
                    state_nxt = FAULT;
            WAIT_RD:
                if (mem_rvalid_i)
                    state_nxt = DONE;
                else if (wd_expired)
                    state_nxt = FAULT;
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            load_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start_i) begin
                we_q    <= !mem_read_i;
                size_q  <= req_size;
                sgn_q   <= read_signed_i;
                off_q   <= addr_i[1:0];
                addr_q  <= {addr_i[31:2], 2'b00};
                be_q    <= be;
                wdata_q <= wdata;
            end
            if (state == WAIT_RD && mem_rvalid_i)
                load_q <= ext;
        end
    end

    // Bus fields are only driven while a request is outstanding.
    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_addr_o  = mem_req_o ? addr_q : '0;
    assign mem_be_o    = mem_req_o ? be_q : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q : '0;

    assign busy_o      = (state == IDLE) ? start_i :
                         (state == REQ || state == WAIT_RD);
    assign done_o      = (state == DONE) || (state == FAULT);
    assign err_o       = (state == FAULT);
    assign load_data_o = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and random
// accesses compared against a byte-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        mem_read_i;
    logic [3:0]  mem_write_i;
    logic [1:0]  read_size_i;
    logic        read_signed_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] load_data_o;
    logic        err_o;

    int vecs = 0;
    int miscompares = 0;
    logic [31:0] model_load = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i),
        .read_size_i(read_size_i),
        .read_signed_i(read_signed_i),
        .addr_i(addr_i),
        .store_data_i(store_data_i),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .load_data_o(load_data_o),
        .err_o(err_o)
    );

    // Caller is positioned at a negedge with the unit idle; returns at
    // the negedge one cycle after the completion pulse (unit idle again).
    task automatic run_txn(input bit rd, input bit [3:0] wr,
                           input bit [1:0] sz, input bit sg,
                           input bit [31:0] a, input bit [31:0] d,
                           input bit [31:0] rdw, input int dly,
                           input bit poke, input string name);
        int nb, lat, edges, waited;
        bit flt, granted, saw_req;
        bit [3:0] ebe;
        bit [31:0] ewd, eld, eaddr;
        longint v;

        nb = rd ? (1 << sz) : (wr == 4'd1 ? 1 : (wr == 4'd3 ? 2 : 4));
        flt = (rd && wr != 4'd0) || (!rd && wr == 4'd0) ||
              (!rd && !(wr inside {4'd1, 4'd3, 4'd15})) ||
              (rd && sz == 2'd3) || ((a % nb) != 0);
        ebe = 4'(((1 << nb) - 1) << (a % 4));
        for (int i = 0; i < 4; i++)
            ewd[8*i +: 8] = d[8*(i % nb) +: 8];
        eaddr = a & 32'hFFFF_FFFC;
        v = longint'(rdw >> (8 * (a % 4)));
        v = v & ((longint'(1) << (8 * nb)) - 1);
        if (sg && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        eld = (rd && !flt) ? 32'(v) : model_load;
        lat = flt ? 2 : ((rd ? 4 : 3) + dly);

        mem_read_i = rd;
        mem_write_i = wr;
        read_size_i = sz;
        read_signed_i = sg;
        addr_i = a;
        store_data_i = d;
        start_i = 1'b1;
        #1;
        vecs++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_at_start got=%b exp=1", name, busy_o);
        end
        @(negedge clk);
        edges = 1;
        waited = 0;
        granted = 0;
        saw_req = 0;
        while (edges < 40) begin
            start_i = 1'b0;
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i = $urandom;
            if (done_o) break;
            if (mem_req_o) begin
                saw_req = 1;
                vecs++;
                if (mem_addr_o !== eaddr || mem_be_o !== ebe ||
                    mem_we_o !== !rd ||
                    (!rd && mem_wdata_o !== ewd)) begin
                    miscompares++;
                    $display("FAIL %s bus got a=%h be=%b we=%b wd=%h exp a=%h be=%b we=%b wd=%h",
                             name, mem_addr_o, mem_be_o, mem_we_o,
                             mem_wdata_o, eaddr, ebe, !rd, ewd);
                end
                if (waited == dly) begin
                    mem_gnt_i = 1'b1;
                    mem_rvalid_i = 1'b1;
                    granted = 1;
                end else begin
                    waited++;
                    if (poke) begin
                        start_i = 1'b1;
                        addr_i = $urandom;
                        mem_write_i = 4'hF;
                        mem_read_i = 1'b0;
                    end
                end
            end else if (granted && rd) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = rdw;
            end
            @(negedge clk);
            edges++;
        end
        start_i = 1'b0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;

        vecs++;
        if (done_o !== 1'b1 || err_o !== flt || edges + 1 != lat) begin
            miscompares++;
            $display("FAIL %s done got done=%b err=%b lat=%0d exp done=1 err=%b lat=%0d",
                     name, done_o, err_o, edges + 1, flt, lat);
        end
        vecs++;
        if (load_data_o !== eld) begin
            miscompares++;
            $display("FAIL %s load_data got=%h exp=%h", name, load_data_o, eld);
        end
        vecs++;
        if (saw_req !== !flt) begin
            miscompares++;
            $display("FAIL %s req_seen got=%b exp=%b", name, saw_req, !flt);
        end
        vecs++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_at_done got=%b exp=0", name, busy_o);
        end
        model_load = eld;
        @(negedge clk);
        vecs++;
        if (done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse_end got done=%b err=%b busy=%b exp 0 0 0",
                     name, done_o, err_o, busy_o);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        vecs++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h0 ||
            mem_be_o !== 4'h0 || mem_wdata_o !== 32'h0 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || err_o !== 1'b0 || load_data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL %s outputs got req=%b we=%b a=%h be=%b wd=%h busy=%b done=%b err=%b ld=%h exp all 0",
                     name, mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
                     mem_wdata_o, busy_o, done_o, err_o, load_data_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_i = 1'b0;
        mem_read_i = 1'b0;
        mem_write_i = 4'h0;
        read_size_i = 2'd0;
        read_signed_i = 1'b0;
        addr_i = 32'h0;
        store_data_i = 32'h0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_load = 32'h0;
    endtask

    task automatic test_store();
        run_txn(0, 4'b1111, 0, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, "sw");
        run_txn(0, 4'b0001, 0, 0, 32'h103, 32'h000000A5, 0, 0, 0, "sb");
        run_txn(0, 4'b0011, 0, 0, 32'h10A, 32'h1234BEEF, 0, 0, 0, "sh");
    endtask

    task automatic test_load();
        run_txn(1, 0, 2'd0, 1, 32'h102, 32'h0, 32'h1280FF00, 0, 0, "lb");
        vecs++;
        if (load_data_o !== 32'hFFFFFF80) begin
            miscompares++;
            $display("FAIL lb_const got=%h exp=ffffff80", load_data_o);
        end
        run_txn(1, 0, 2'd0, 0, 32'h102, 32'h0, 32'h1280FF00, 0, 0, "lbu");
        vecs++;
        if (load_data_o !== 32'h00000080) begin
            miscompares++;
            $display("FAIL lbu_const got=%h exp=00000080", load_data_o);
        end
        run_txn(1, 0, 2'd1, 1, 32'h202, 32'h0, 32'h80011234, 0, 0, "lh");
        vecs++;
        if (load_data_o !== 32'hFFFF8001) begin
            miscompares++;
            $display("FAIL lh_const got=%h exp=ffff8001", load_data_o);
        end
        run_txn(1, 0, 2'd2, 0, 32'h204, 32'h0, 32'h12345678, 0, 0, "lw");
        run_txn(1, 0, 2'd1, 0, 32'h206, 32'h0, 32'h9ABC5678, 1, 0, "lhu");
    endtask

    task automatic test_fault();
        run_txn(1, 0, 2'd2, 0, 32'h101, 0, 32'h55, 0, 0, "lw_mis");
        run_txn(0, 4'b0011, 0, 0, 32'h103, 32'hCAFE, 0, 0, 0, "sh_mis");
        run_txn(1, 4'b1111, 2'd2, 0, 32'h100, 0, 0, 0, 0, "rd_and_wr");
        run_txn(0, 4'b0000, 2'd2, 0, 32'h100, 0, 0, 0, 0, "no_op");
        run_txn(0, 4'b0101, 0, 0, 32'h100, 0, 0, 0, 0, "bad_mask");
        run_txn(1, 0, 2'd3, 0, 32'h100, 0, 0, 0, 0, "bad_size");
    endtask

    task automatic test_start_ignored();
        run_txn(0, 4'b1111, 0, 0, 32'h440, 32'h0BADF00D, 0, 3, 1, "poke_sw");
        run_txn(1, 0, 2'd0, 1, 32'h441, 0, 32'h0000F700, 2, 1, "poke_lb");
    endtask

    task automatic test_reset_mid();
        mem_read_i = 1'b1;
        mem_write_i = 4'h0;
        read_size_i = 2'd2;
        read_signed_i = 1'b0;
        addr_i = 32'h300;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        addr_i = 32'h0;
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300 ||
                mem_be_o !== 4'hF || mem_we_o !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_req%0d got req=%b a=%h be=%b we=%b exp 1 00000300 1111 0",
                         k, mem_req_o, mem_addr_o, mem_be_o, mem_we_o);
            end
            mem_gnt_i = (k == 5);
            @(negedge clk);
        end
        mem_gnt_i = 1'b0;
        vecs++;
        if (mem_req_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_rd got req=%b busy=%b exp 0 1", mem_req_o, busy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        model_load = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1, 0, 2'd2, 0, 32'h204, 0, 32'h12345678, 0, 0, "lw_after_rst");
    endtask

    task automatic test_random();
        bit rd, sg, poke;
        bit [3:0] wr;
        bit [1:0] sz;
        int pick;
        for (int n = 0; n < 80; n++) begin
            rd = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            if (rd) wr = (pick == 0) ? 4'hF : 4'h0;
            else if (pick < 3) wr = 4'd1;
            else if (pick < 6) wr = 4'd3;
            else if (pick < 9) wr = 4'd15;
            else wr = 4'($urandom);
            sz = (rd && pick == 1) ? 2'd3 : 2'($urandom_range(0, 2));
            sg = 1'($urandom_range(0, 1));
            poke = 1'($urandom_range(0, 1));
            run_txn(rd, wr, sz, sg, $urandom, $urandom, $urandom,
                    $urandom_range(0, 2), poke, "random");
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_fault();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
